// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Purpose: drives the PLL reset from the 50 MHz reference clock. It also
// qualifies the PLL's asynchronous locked flag, and only then releases the
// downstream system reset (the ADC capture and UART domains). The lock must
// first have been stable for STABLE_CYCLES. The PLL is retried on lock
// timeout. After MAX_RETRIES attempts a sticky failure is flagged.
//
// Ports:
//   refclk      in   1  reference clock, the only clock in this block
//   rst_n       in   1  asynchronous active-low reset
//   pll_locked  in   1  PLL locked flag, asynchronous to refclk
//   pll_rst     out  1  active-high PLL reset
//   sys_rst_n   out  1  active-low downstream reset, high only in RUN
//   lock_ok     out  1  high while in RUN
//   lock_fail   out  1  high while in FAIL (sticky until rst_n)
//   lock_lost   out  1  one-cycle pulse when lock drops in RUN
//   retry_count out  4  lock timeouts since the last entry to RUN
//
// All outputs are registered.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_ok,
  output logic       lock_fail,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  // One counter serves every state, so it is sized for the longest interval.
  // It never wraps: each terminal count forces a state change.
  localparam int CNT_MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_AB > STABLE_CYCLES) ? CNT_MAX_AB : STABLE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   locked_s;
  logic [3:0]             retry_r;
  logic [3:0]             retry_inc_s;
  logic                   pll_rst_r;
  logic                   sys_rst_n_r;
  logic                   lock_ok_r;
  logic                   lock_fail_r;
  logic                   lock_lost_r;

  // Synchroniser for the asynchronous pll_locked flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_r[SYNC_STAGES-1];

  // Saturating increment of the retry counter.
  always_comb begin
    retry_inc_s = retry_r;
    if (retry_r == RETRY_MAX) begin
      retry_inc_s = retry_r;
    end else begin
      retry_inc_s = retry_r + 4'd1;
    end
  end

  // Supervisor FSM: the state, the shared counter and all registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RESET_PLL;
      cnt_r       <= CNT_ZERO;
      retry_r     <= 4'd0;
      pll_rst_r   <= 1'b1;
      sys_rst_n_r <= 1'b0;
      lock_ok_r   <= 1'b0;
      lock_fail_r <= 1'b0;
      lock_lost_r <= 1'b0;
    end else begin
      // lock_lost is a pulse; only the RUN lock-loss branch raises it.
      lock_lost_r <= 1'b0;
      case (state_r)
        ST_RESET_PLL: begin
          // locked_s is deliberately ignored while the PLL is held in reset.
          sys_rst_n_r <= 1'b0;
          lock_ok_r   <= 1'b0;
          if (cnt_r == RESET_LAST) begin
            state_r   <= ST_WAIT_LOCK;
            cnt_r     <= CNT_ZERO;
            pll_rst_r <= 1'b0;
          end else begin
            cnt_r     <= cnt_r + CNT_ONE;
            pll_rst_r <= 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock takes priority over a timeout that lands on the same cycle.
          if (locked_s) begin
            state_r <= ST_STABLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == TIMEOUT_LAST) begin
            retry_r   <= retry_inc_s;
            cnt_r     <= CNT_ZERO;
            pll_rst_r <= 1'b1;
            if (retry_inc_s == RETRY_MAX) begin
              state_r     <= ST_FAIL;
              lock_fail_r <= 1'b1;
            end else begin
              state_r <= ST_RESET_PLL;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_STABLE: begin
          // A glitch restarts the lock wait with a fresh timeout window.
          // It does not count as a retry.
          if (!locked_s) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == STABLE_LAST) begin
            state_r     <= ST_RUN;
            cnt_r       <= CNT_ZERO;
            retry_r     <= 4'd0;
            sys_rst_n_r <= 1'b1;
            lock_ok_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_RUN: begin
          // Downstream reset drops on the same edge that lock loss is seen.
          if (!locked_s) begin
            state_r     <= ST_RESET_PLL;
            cnt_r       <= CNT_ZERO;
            pll_rst_r   <= 1'b1;
            sys_rst_n_r <= 1'b0;
            lock_ok_r   <= 1'b0;
            lock_lost_r <= 1'b1;
          end else begin
            sys_rst_n_r <= 1'b1;
            lock_ok_r   <= 1'b1;
          end
        end

        ST_FAIL: begin
          // Terminal: only rst_n leaves this state.
          pll_rst_r   <= 1'b1;
          sys_rst_n_r <= 1'b0;
          lock_ok_r   <= 1'b0;
          lock_fail_r <= 1'b1;
        end

        default: begin
          state_r     <= ST_RESET_PLL;
          cnt_r       <= CNT_ZERO;
          pll_rst_r   <= 1'b1;
          sys_rst_n_r <= 1'b0;
          lock_ok_r   <= 1'b0;
          lock_fail_r <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst     = pll_rst_r;
  assign sys_rst_n   = sys_rst_n_r;
  assign lock_ok     = lock_ok_r;
  assign lock_fail   = lock_fail_r;
  assign lock_lost   = lock_lost_r;
  assign retry_count = retry_r;

endmodule
